sha3_pad_packer: RTL and testbench

- Upstream feeder for the AXI-Stream SHA3 core.
- Takes a raw message as an AXI-Stream of DATA_WIDTH words with byte-enables and a per-message variant select.
- Emits rate-sized, SHA3-padded blocks: message bytes, domain byte 0x06, zero fill, final 0x80.
- Marks block ends and message end so the core can absorb and permute without software padding.

---
 rtl/sha3_pad_packer.sv | 190 +++++++++++++++++++
 tb/tb_sha3_pad_packer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sha3_pad_packer.sv
// Packs a raw AXI-Stream message into SHA3-padded rate blocks for the SHA3 core.
// Optional SHAKE domain select is enabled by defining SHA3_PAD_SHAKE_EN.
module sha3_pad_packer #(
  parameter  int DATA_WIDTH = 32,
  localparam int KEEP_W     = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_W-1:0]     s_tkeep,
  input  logic [1:0]            s_tuser,
`ifdef SHA3_PAD_SHAKE_EN
  input  logic                  s_shake,
`endif
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [1:0]            m_tuser,
  output logic                  m_tlast,
  output logic                  m_tid,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  err
);

  localparam int CW = 8;

  typedef enum logic [1:0] {IDLE, MSG, PAD, FILL} state_t;

  state_t                state_reg, state_next;
  logic [CW-1:0]         wcnt_reg;
  logic [1:0]            variant_reg;
  logic [DATA_WIDTH-1:0] m_tdata_reg;
  logic [1:0]            m_tuser_reg;
  logic                  m_tlast_reg;
  logic                  m_tid_reg;
  logic                  m_tvalid_reg;
  logic                  err_reg;

  logic                  out_free;
  logic                  accept;
  logic [1:0]            cur_variant;
  logic [7:0]            domain;
  logic                  keep_full;
  logic                  keep_bad;
  logic [KEEP_W-1:0]     dom_mask;
  logic [DATA_WIDTH-1:0] part_word;
  logic                  block_end;
  logic                  load;
  logic                  tid_next;
  logic [DATA_WIDTH-1:0] word_next;

  function automatic logic [CW-1:0] rate_words(input logic [1:0] v);
    case (v)
      2'd0:    return CW'((1600 - 448) / DATA_WIDTH);
      2'd1:    return CW'((1600 - 512) / DATA_WIDTH);
      2'd2:    return CW'((1600 - 768) / DATA_WIDTH);
      default: return CW'((1600 - 1024) / DATA_WIDTH);
    endcase
  endfunction

  assign out_free    = !m_tvalid_reg | m_tready;
  assign s_tready    = ((state_reg == IDLE) || (state_reg == MSG)) && out_free;
  assign accept      = s_tvalid & s_tready;
  // The first beat of a message sees the new variant before it is latched.
  assign cur_variant = (state_reg == IDLE) ? s_tuser : variant_reg;
  assign block_end   = (wcnt_reg == rate_words(cur_variant) - CW'(1));

`ifdef SHA3_PAD_SHAKE_EN
  logic shake_reg;
  logic cur_shake;
  assign cur_shake = (state_reg == IDLE) ? s_shake : shake_reg;
  assign domain    = cur_shake ? 8'h1F : 8'h06;
`else
  assign domain    = 8'h06;
`endif

  assign keep_full = &s_tkeep;
  assign keep_bad  = ((s_tkeep & (s_tkeep + KEEP_W'(1))) != '0) || (!s_tlast && !keep_full);
  // One-hot position of the first disabled byte above the kept run.
  assign dom_mask  = ((s_tkeep << 1) | KEEP_W'(1)) & ~s_tkeep;

  genvar gi;
  generate
    for (gi = 0; gi < KEEP_W; gi++) begin : g_lane
      assign part_word[8*gi +: 8] = s_tkeep[gi]  ? s_tdata[8*gi +: 8] :
                                    dom_mask[gi] ? domain : 8'h00;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    tid_next   = 1'b0;
    word_next  = '0;
    case (state_reg)
      IDLE, MSG: begin
        if (accept) begin
          load       = 1'b1;
          word_next  = s_tdata;
          state_next = MSG;
          if (s_tlast) begin
            if (keep_bad || keep_full) begin
              state_next = PAD;
            end else begin
              word_next = part_word;
              if (block_end) begin
                word_next[DATA_WIDTH-1 -: 8] = part_word[DATA_WIDTH-1 -: 8] | 8'h80;
                tid_next   = 1'b1;
                state_next = IDLE;
              end else begin
                state_next = FILL;
              end
            end
          end
        end
      end
      PAD: begin
        if (out_free) begin
          load           = 1'b1;
          word_next[7:0] = domain;
          if (block_end) begin
            word_next[DATA_WIDTH-1 -: 8] = word_next[DATA_WIDTH-1 -: 8] | 8'h80;
            tid_next   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = FILL;
          end
        end
      end
      default: begin
        if (out_free) begin
          load = 1'b1;
          if (block_end) begin
            word_next[DATA_WIDTH-1 -: 8] = 8'h80;
            tid_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_reg    <= IDLE;
      wcnt_reg     <= '0;
      variant_reg  <= '0;
      m_tdata_reg  <= '0;
      m_tuser_reg  <= '0;
      m_tlast_reg  <= 1'b0;
      m_tid_reg    <= 1'b0;
      m_tvalid_reg <= 1'b0;
      err_reg      <= 1'b0;
`ifdef SHA3_PAD_SHAKE_EN
      shake_reg    <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept && (state_reg == IDLE)) begin
        variant_reg <= s_tuser;
`ifdef SHA3_PAD_SHAKE_EN
        shake_reg   <= s_shake;
`endif
      end
      if (accept && keep_bad) begin
        err_reg <= 1'b1;
      end
      if (load) begin
        m_tdata_reg  <= word_next;
        m_tuser_reg  <= cur_variant;
        m_tlast_reg  <= block_end;
        m_tid_reg    <= tid_next;
        m_tvalid_reg <= 1'b1;
        wcnt_reg     <= block_end ? '0 : wcnt_reg + CW'(1);
      end else if (m_tready) begin
        m_tvalid_reg <= 1'b0;
      end
    end
  end

  assign m_tdata  = m_tdata_reg;
  assign m_tuser  = m_tuser_reg;
  assign m_tlast  = m_tlast_reg;
  assign m_tid    = m_tid_reg;
  assign m_tvalid = m_tvalid_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_sha3_pad_packer.sv
// Bench for sha3_pad_packer: byte-level SHA3 padding reference model, random and directed messages.
module tb_sha3_pad_packer;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic [1:0]  s_tuser = '0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [1:0]  m_tuser;
  logic        m_tlast;
  logic        m_tid;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic        err;

  int errors = 0;
  int checks = 0;
  byte unsigned msg_q[$];

  sha3_pad_packer #(.DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tid(m_tid),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .err(err)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sends msg_q as one message with variant v; rmode 0 = always ready,
  // 1 = random valid/ready gaps, 2 = m_tready pattern 1,0,0,1.
  // Entered and left one time unit after a rising edge.
  task automatic run_msg(input logic [1:0] v, input int rmode);
    byte unsigned p[$];
    logic [35:0]  exp_q[$];
    logic [35:0]  held, got;
    int len, sha, rb, rw, nw, nb, bi, wi, cyc;
    bit have_hold, lat_pending, acc, fire;
    len = msg_q.size();
    sha = (v == 0) ? 224 : (v == 1) ? 256 : (v == 2) ? 384 : 512;
    rb  = (1600 - 2 * sha) / 8;
    rw  = rb / 4;
    p = msg_q;
    p.push_back(8'h06);
    while (p.size() % rb != 0) p.push_back(8'h00);
    p[p.size() - 1] = p[p.size() - 1] | 8'h80;
    nw = p.size() / 4;
    for (int w = 0; w < nw; w++)
      exp_q.push_back({v, 1'((w + 1) % rw == 0), 1'(w == nw - 1),
                       p[4*w+3], p[4*w+2], p[4*w+1], p[4*w]});
    nb = (len % 4 == 0 && len > 0) ? len / 4 : len / 4 + 1;
    bi = 0; wi = 0; cyc = 0;
    have_hold = 0; lat_pending = 0; held = '0;
    while (wi < nw && cyc < 3000) begin
      s_tvalid = (bi < nb) && (rmode != 1 || $urandom_range(0, 3) != 0);
      s_tuser  = (bi == 0) ? v : 2'($urandom);
      s_tlast  = (bi == nb - 1);
      for (int i = 0; i < 4; i++) begin
        if (4 * bi + i < len) begin
          s_tdata[8*i +: 8] = msg_q[4*bi+i];
          s_tkeep[i] = 1'b1;
        end else begin
          s_tdata[8*i +: 8] = 8'($urandom);
          s_tkeep[i] = 1'b0;
        end
      end
      if (rmode == 0) m_tready = 1'b1;
      else if (rmode == 1) m_tready = ($urandom_range(0, 2) != 0);
      else m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      @(negedge ACLK);
      got = {m_tuser, m_tlast, m_tid, m_tdata};
      if (lat_pending) chk("latency_valid", 64'(m_tvalid), 64'd1);
      if (have_hold) begin
        chk("stall_valid", 64'(m_tvalid), 64'd1);
        chk("stall_hold", 64'(got), 64'(held));
      end
      have_hold = m_tvalid && !m_tready;
      if (have_hold) begin
        held = got;
        chk("stall_sready", 64'(s_tready), 64'd0);
      end
      acc  = s_tvalid && s_tready;
      fire = m_tvalid && m_tready;
      if (fire) begin
        chk($sformatf("word%0d", wi), 64'(got), 64'(exp_q[wi]));
        wi++;
      end
      lat_pending = acc;
      if (acc) bi++;
      @(posedge ACLK); #1;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    chk("msg_complete", 64'(wi), 64'(nw));
    chk("err_clear", 64'(err), 64'd0);
    $display("msg len=%0d variant=%0d words=%0d/%0d beats=%0d cycles=%0d", len, v, wi, nw, bi, cyc);
  endtask

  initial begin
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    chk("rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_tdata", 64'(m_tdata), 64'd0);
    chk("rst_tlast", 64'(m_tlast), 64'd0);
    chk("rst_tid", 64'(m_tid), 64'd0);
    chk("rst_tuser", 64'(m_tuser), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_sready", 64'(s_tready), 64'd1);
    @(posedge ACLK); #1;

    // Empty message, variant 256
    msg_q.delete();
    run_msg(2'd1, 0);

    // "abc", variant 256, with stalls
    msg_q.delete();
    msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
    run_msg(2'd1, 2);

    // 71 bytes at variant 512: padding merges into the block's final byte
    msg_q.delete();
    for (int i = 0; i < 71; i++) msg_q.push_back(8'($urandom));
    run_msg(2'd3, 0);

    // 72 bytes at variant 512: exact block fill forces a padding block
    msg_q.delete();
    for (int i = 0; i < 72; i++) msg_q.push_back(8'($urandom));
    run_msg(2'd3, 1);

    // Random messages with random handshakes
    for (int m = 0; m < 10; m++) begin
      msg_q.delete();
      for (int i = 0, n = $urandom_range(0, 200); i < n; i++) msg_q.push_back(8'($urandom));
      run_msg(2'($urandom), 1);
    end

    // Reset while in FILL, then keep violation
    s_tvalid = 1'b1; s_tdata = 32'h0063_6261; s_tkeep = 4'b0111; s_tlast = 1'b1;
    s_tuser = 2'd1; m_tready = 1'b1;
    @(posedge ACLK); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (3) begin @(posedge ACLK); #1; end
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_sready", 64'(s_tready), 64'd1);
    chk("midrst_err", 64'(err), 64'd0);
    repeat (3) begin
      @(negedge ACLK);
      chk("midrst_no_drain", 64'(m_tvalid), 64'd0);
    end
    @(posedge ACLK); #1;
    s_tvalid = 1'b1; s_tdata = 32'hA5C3_1234; s_tkeep = 4'b0011; s_tlast = 1'b0;
    s_tuser = 2'd2; m_tready = 1'b0;
    @(negedge ACLK);
    chk("bad_sready", 64'(s_tready), 64'd1);
    @(posedge ACLK); #1;
    s_tvalid = 1'b0;
    @(negedge ACLK);
    chk("bad_err", 64'(err), 64'd1);
    chk("bad_tvalid", 64'(m_tvalid), 64'd1);
    chk("bad_tdata", 64'(m_tdata), 64'hA5C3_1234);
    chk("bad_tuser", 64'(m_tuser), 64'd2);
    chk("bad_tlast", 64'(m_tlast), 64'd0);
    m_tready = 1'b1;
    repeat (4) @(negedge ACLK);
    chk("err_sticky", 64'(err), 64'd1);
    @(posedge ACLK); #1;
    ARESETn = 1'b0;
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    chk("err_rst", 64'(err), 64'd0);
    chk("err_rst_tvalid", 64'(m_tvalid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
